branch_cmp_pht: RTL and testbench
=================================

Name: branch_cmp_pht

Overview:
- Next-generation ID-stage branch comparator for the pipelined MIPS core.
- Generalises the 2-bit equality-only comparator in three ways:
  - parametrised data width;
  - full 3-bit compare-op set (beq/bne/blez/bgtz/bltz/bgez);
  - a PHT_DEPTH-entry pattern history table of 2-bit saturating counters.
- IF queries the table for a taken/not-taken prediction.
- ID resolves the branch, flags mispredicts and trains the table.
- Also keeps branch/mispredict statistics counters.

Parameters:
- WIDTH, 32, operand width of rd1/rd2.
- IDX_W, 6, PHT index width; PHT_DEPTH = 2**IDX_W entries.
- CTR_INIT, 2'b01, reset value of every PHT counter (weakly not-taken).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-low reset.
- stall  input  1  ID stage stalled; blocks PHT and statistics updates.
- if_pc  input  32  PC of the instruction in IF (lookup).
- pred_taken  output  1  prediction for if_pc.
- id_valid  input  1  ID holds a real instruction (not a bubble).
- id_pc  input  32  PC of the instruction in ID.
- id_pred_taken  input  1  prediction carried down the pipeline from IF.
- cmp_op  input  3  compare operation.
- rd1  input  WIDTH  forwarded rs value.
- rd2  input  WIDTH  forwarded rt value.
- cmp_out  output  1  branch condition result.
- mispredict  output  1  flush/redirect request.
- branch_cnt  output  32  resolved-branch count.
- mispred_cnt  output  32  mispredict count.

Behaviour:
- Index: lookup idx = if_pc[IDX_W+1:2]; update idx = id_pc[IDX_W+1:2]. PC bits [1:0] are ignored.
- cmp_op encoding (signed compares on rd1, two's complement WIDTH bits):
  - 000 beq: rd1==rd2.
  - 001 bne: rd1!=rd2.
  - 010 blez: rd1<=0.
  - 011 bgtz: rd1>0.
  - 100 bltz: rd1[WIDTH-1].
  - 101 bgez: !rd1[WIDTH-1].
  - 110/111: not a branch; cmp_out=0.
- is_br = id_valid && cmp_op<=3'b101.
- cmp_out: combinational, zero latency, independent of id_valid and stall.
- mispredict: combinational = is_br && (cmp_out != id_pred_taken). It is asserted even while stall=1; the hazard unit qualifies it.
- pred_taken: combinational = PHT[lookup idx][1].
- PHT update, posedge, when reset=1 && is_br && !stall:
  - cmp_out=1: counter += 1, saturating at 2'b11.
  - cmp_out=0: counter -= 1, saturating at 2'b00.
  - Non-branch, bubble or stalled cycles leave the PHT unchanged.
- Same-cycle lookup and update to the same index: pred_taken shows the pre-update value (read-before-write, no bypass). The new value is visible from the next cycle.
- Statistics, same qualifier as the PHT update:
  - branch_cnt += 1.
  - mispred_cnt += 1 if mispredict.
  - Both saturate at 32'hFFFF_FFFF; no wrap.
- Reset (reset=0 at posedge):
  - All PHT entries become CTR_INIT; branch_cnt=0; mispred_cnt=0.
  - Takes effect in one cycle, overriding any simultaneous update.
  - With default CTR_INIT, pred_taken=0 for every PC after reset.
  - Reset mid-training discards all history.
- Outputs after reset with id_valid=0: pred_taken=CTR_INIT[1], cmp_out per inputs, mispredict=0, counters 0.
- Storage: flops, not block RAM, so that the one-cycle full reset holds.

Test Plan:
- Compare ops, WIDTH=32:
  - rd1=32'h8000_0000, rd2=0: bltz=1, blez=1, bgtz=0, bgez=0, beq=0, bne=1.
  - rd1=0: blez=1, bgez=1, bgtz=0.
  - cmp_op=3'b110: cmp_out=0, no counter change.
- Training: reset, then id_pc=if_pc=32'h0000_3004 (idx 1), taken branch with id_pred_taken=0 for 3 unstalled cycles.
  - Cycle 1: pred_taken stays 0 (read-before-write), mispredict=1.
  - From cycle 2: pred_taken=1.
  - After 3 cycles: counter=2'b11, branch_cnt=3, mispred_cnt=3.
- Saturation/decay: from counter 11, apply 1 not-taken → pred_taken still 1; apply a 2nd not-taken → pred_taken=0; 3 more not-taken → counter holds 00.
- Stall/bubble: taken branch with stall=1, or with id_valid=0, for 5 cycles → PHT and both counters unchanged; mispredict follows is_br.
- Aliasing: id_pc=32'h0000_3004 and 32'h0000_3104 (IDX_W=6) share entry 1; training one changes the prediction of the other.
- Reset mid-operation: counters nonzero and a branch resolving in the same cycle as reset=0 → next cycle counters=0 and all entries read CTR_INIT.

Source files
------------

// File: rtl/branch_cmp_pht.sv
// ---------------------------------------------------------------------------
// branch_cmp_pht
//
// ID-stage branch comparator with a pattern history table (PHT) of 2-bit
// saturating counters and branch/mispredict statistics.
//
// The IF stage looks up a taken/not-taken prediction for if_pc. The ID stage
// resolves the branch from the forwarded operands, flags a mispredict against
// the prediction carried down from IF, and trains the PHT entry of id_pc.
//
// Ports:
//   clk           in   clock, all state updates on posedge
//   reset         in   synchronous, active-low reset
//   stall         in   ID stalled: blocks PHT and statistics updates
//   if_pc         in   [31:0] PC in IF (lookup)
//   pred_taken    out  prediction for if_pc
//   id_valid      in   ID holds a real instruction (not a bubble)
//   id_pc         in   [31:0] PC in ID (update)
//   id_pred_taken in   prediction carried from IF
//   cmp_op        in   [2:0] compare operation
//   rd1, rd2      in   [WIDTH-1:0] forwarded rs / rt values
//   cmp_out       out  branch condition result (combinational)
//   mispredict    out  flush/redirect request (combinational)
//   branch_cnt    out  [31:0] resolved-branch count (saturating)
//   mispred_cnt   out  [31:0] mispredict count (saturating)
// ---------------------------------------------------------------------------
module branch_cmp_pht #(
    parameter int         WIDTH    = 32,
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    input  logic             id_valid,
    input  logic [31:0]      id_pc,
    input  logic             id_pred_taken,
    input  logic [2:0]       cmp_op,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             cmp_out,
    output logic             mispredict,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
);

    localparam int PHT_DEPTH = 2 ** IDX_W;

    // Flop-based table so that a single reset cycle clears every entry.
    logic [1:0]       pht [PHT_DEPTH];
    logic [IDX_W-1:0] lkp_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             is_br;
    logic             do_update;
    logic             rd1_neg;
    logic             rd1_zero;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_nxt;
    logic             unused_pc_bits;

    // Word-aligned PCs: bits [1:0] never select an entry.
    assign lkp_idx = if_pc[IDX_W+1:2];
    assign upd_idx = id_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                              id_pc[31:IDX_W+2], id_pc[1:0]};

    assign rd1_neg  = rd1[WIDTH-1];
    assign rd1_zero = (rd1 == '0);

    always_comb begin
        cmp_out = 1'b0;
        case (cmp_op)
            3'b000:  cmp_out = (rd1 == rd2);
            3'b001:  cmp_out = (rd1 != rd2);
            3'b010:  cmp_out = rd1_neg || rd1_zero;     // blez
            3'b011:  cmp_out = !rd1_neg && !rd1_zero;   // bgtz
            3'b100:  cmp_out = rd1_neg;                 // bltz
            3'b101:  cmp_out = !rd1_neg;                // bgez
            default: cmp_out = 1'b0;                    // not a branch
        endcase
    end

    assign is_br      = id_valid && (cmp_op <= 3'b101);
    // Not gated by stall: the hazard unit decides whether to act on it.
    assign mispredict = is_br && (cmp_out != id_pred_taken);
    assign do_update  = is_br && !stall;

    // Read-before-write: a same-cycle update is only visible next cycle.
    assign pred_taken = pht[lkp_idx][1];

    always_comb begin
        ctr_cur = pht[upd_idx];
        ctr_nxt = ctr_cur;
        if (cmp_out) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                pht[i] <= CTR_INIT;
            end
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (do_update) begin
            pht[upd_idx] <= ctr_nxt;
            if (branch_cnt != 32'hFFFF_FFFF) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp_pht.sv
// ---------------------------------------------------------------------------
// tb_branch_cmp_pht
//
// Directed bench for branch_cmp_pht (default parameters). Inputs change 1ns
// after a rising edge; outputs are sampled 1ns later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_branch_cmp_pht;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [2:0]  cmp_op;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        cmp_out;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks;
    int failures;

    branch_cmp_pht dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_pred_taken (id_pred_taken),
        .cmp_op        (cmp_op),
        .rd1           (rd1),
        .rd2           (rd2),
        .cmp_out       (cmp_out),
        .mispredict    (mispredict),
        .branch_cnt    (branch_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        id_valid      = 1'b0;
        id_pc         = 32'h0;
        if_pc         = 32'h0;
        id_pred_taken = 1'b0;
        cmp_op        = 3'b110;
        rd1           = 32'h0;
        rd2           = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Taken branch: beq with equal operands.
    task automatic drive_taken(input logic [31:0] pc, input logic pred);
        id_valid      = 1'b1;
        id_pc         = pc;
        id_pred_taken = pred;
        cmp_op        = 3'b000;
        rd1           = 32'h5;
        rd2           = 32'h5;
    endtask

    // Not-taken branch: bne with equal operands.
    task automatic drive_not_taken(input logic [31:0] pc, input logic pred);
        id_valid      = 1'b1;
        id_pc         = pc;
        id_pred_taken = pred;
        cmp_op        = 3'b001;
        rd1           = 32'h7;
        rd2           = 32'h7;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        settle();
        for (int k = 0; k < 4; k++) begin
            if_pc = 32'h0000_1000 + 32'(k * 36);
            settle();
            checks++;
            if (pred_taken !== 1'b0) begin
                failures++;
                $display("FAIL reset_pred pc=%h got=%b exp=0", if_pc, pred_taken);
            end
        end
        checks++;
        if (mispredict !== 1'b0) begin
            failures++;
            $display("FAIL reset_mispredict got=%b exp=0", mispredict);
        end
        checks++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_cmp_ops();
        logic [2:0]  ops [12];
        logic [31:0] a   [12];
        logic [31:0] b   [12];
        logic        exp [12];
        ops = '{3'b100, 3'b010, 3'b011, 3'b101, 3'b000, 3'b001,
                3'b010, 3'b101, 3'b011, 3'b011, 3'b000, 3'b111};
        a   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 32'h0,
                32'h0000_0001, 32'h1234_5678, 32'h1234_5678};
        b   = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h1234_5678, 32'h1234_5678};
        exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        id_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cmp_op = ops[i];
            rd1    = a[i];
            rd2    = b[i];
            settle();
            checks++;
            if (cmp_out !== exp[i]) begin
                failures++;
                $display("FAIL cmp_op%0d op=%b rd1=%h rd2=%h got=%b exp=%b",
                         i, ops[i], a[i], b[i], cmp_out, exp[i]);
            end
        end
        // Valid instruction with a non-branch op: no mispredict, no counting.
        id_valid      = 1'b1;
        id_pred_taken = 1'b1;
        cmp_op        = 3'b110;
        rd1           = 32'h3;
        rd2           = 32'h3;
        settle();
        checks++;
        if (cmp_out !== 1'b0 || mispredict !== 1'b0) begin
            failures++;
            $display("FAIL nonbranch_out got=%b/%b exp=0/0", cmp_out, mispredict);
        end
        tick();
        checks++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            failures++;
            $display("FAIL nonbranch_counts got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_training();
        logic exp_pred [3];
        exp_pred = '{1'b0, 1'b1, 1'b1};
        do_reset();
        if_pc = 32'h0000_3004;
        drive_taken(32'h0000_3004, 1'b0);
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (pred_taken !== exp_pred[c] || mispredict !== 1'b1) begin
                failures++;
                $display("FAIL train_cycle%0d pred/mis got=%b/%b exp=%b/1",
                         c + 1, pred_taken, mispredict, exp_pred[c]);
            end
            tick();
        end
        checks++;
        if (branch_cnt !== 32'd3 || mispred_cnt !== 32'd3) begin
            failures++;
            $display("FAIL train_counts got=%0d/%0d exp=3/3", branch_cnt, mispred_cnt);
        end
    endtask

    // Continues from counter 11 at index 1.
    task automatic test_decay();
        logic exp_pred [5];
        exp_pred = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        if_pc = 32'h0000_3004;
        drive_not_taken(32'h0000_3004, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (pred_taken !== exp_pred[c]) begin
                failures++;
                $display("FAIL decay_nt%0d got=%b exp=%b", c + 1, pred_taken, exp_pred[c]);
            end
        end
        // Counter must be 00: one taken gives 01, still predicting not-taken.
        drive_taken(32'h0000_3004, 1'b1);
        tick();
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL decay_floor got=%b exp=0", pred_taken);
        end
        checks++;
        if (branch_cnt !== 32'd9 || mispred_cnt !== 32'd8) begin
            failures++;
            $display("FAIL decay_counts got=%0d/%0d exp=9/8", branch_cnt, mispred_cnt);
        end
    endtask

    // Continues from counter 01 at index 1, counts 9/8.
    task automatic test_stall_bubble();
        if_pc = 32'h0000_3004;
        drive_taken(32'h0000_3004, 1'b0);
        stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (mispredict !== 1'b1) begin
                failures++;
                $display("FAIL stall_mispredict%0d got=%b exp=1", c, mispredict);
            end
            tick();
        end
        stall    = 1'b0;
        id_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            checks++;
            if (mispredict !== 1'b0) begin
                failures++;
                $display("FAIL bubble_mispredict%0d got=%b exp=0", c, mispredict);
            end
            tick();
        end
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL stall_pht got=%b exp=0", pred_taken);
        end
        checks++;
        if (branch_cnt !== 32'd9 || mispred_cnt !== 32'd8) begin
            failures++;
            $display("FAIL stall_counts got=%0d/%0d exp=9/8", branch_cnt, mispred_cnt);
        end
        // 01 -> 10 proves the stall/bubble cycles left the entry at 01.
        drive_taken(32'h0000_3004, 1'b0);
        tick();
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL stall_pht_probe got=%b exp=1", pred_taken);
        end
        idle_inputs();
    endtask

    task automatic test_aliasing();
        do_reset();
        drive_taken(32'h0000_3104, 1'b0);
        tick();
        id_valid = 1'b0;
        if_pc    = 32'h0000_3004;
        settle();
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL alias_shared got=%b exp=1", pred_taken);
        end
        if_pc = 32'h0000_3008;
        settle();
        checks++;
        if (pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL alias_neighbour got=%b exp=0", pred_taken);
        end
        // Low PC bits are ignored.
        if_pc = 32'h0000_3107;
        settle();
        checks++;
        if (pred_taken !== 1'b1) begin
            failures++;
            $display("FAIL alias_lowbits got=%b exp=1", pred_taken);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        drive_taken(32'h0000_3004, 1'b0);
        tick();
        tick();
        // Branch resolves in the same cycle reset is asserted.
        reset = 1'b0;
        tick();
        reset    = 1'b1;
        id_valid = 1'b0;
        settle();
        checks++;
        if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt);
        end
        bad = 0;
        for (int e = 0; e < 64; e++) begin
            if_pc = 32'(e) << 2;
            settle();
            if (pred_taken !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rstmid_entries nonzero_preds=%0d exp=0", bad);
        end
        // One taken from CTR_INIT (01) must reach 10.
        if_pc = 32'h0000_3004;
        drive_taken(32'h0000_3004, 1'b0);
        tick();
        checks++;
        if (pred_taken !== 1'b1 || branch_cnt !== 32'd1) begin
            failures++;
            $display("FAIL rstmid_probe got=%b/%0d exp=1/1", pred_taken, branch_cnt);
        end
        idle_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        idle_inputs();
        test_reset();
        test_cmp_ops();
        test_training();
        test_decay();
        test_stall_bubble();
        test_aliasing();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
